fir_sched: RTL and testbench
============================

FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one fir instance, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in WAIT, used only with the Configuration macro.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, NUM_REQ: per-requester call request.
REQ-006 Port req_ready, output, NUM_REQ: one-cycle acceptance pulse to the granted requester.
REQ-007 Port req_idx, input, NUM_REQ*32: packed idx operands; requester i occupies bits [32i+31:32i].
REQ-008 Port req_taps, input, NUM_REQ*32: packed taps operands, packed the same way as req_idx.
REQ-009 Port rsp_valid, output, NUM_REQ: result valid for the owning requester.
REQ-010 Port rsp_ready, input, NUM_REQ: requester accepts the result.
REQ-011 Port rsp_data, output, 32: result shared by all requesters.
REQ-012 Ports fir_start out 1, fir_busy in 1, fir_done in 1, fir_stall out 1: fir call/return handshake.
REQ-013 Ports fir_idx out 32, fir_taps out 32, fir_returndata in 32: fir operands and result.
REQ-014 Port sched_busy, output, 1: high in any state other than IDLE.
REQ-015 Port timeout_err, output, 1: one-cycle watchdog pulse.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 In IDLE with any req_valid bit high, the scheduler SHALL grant round-robin, starting from the index after the last served requester, then:
- pulse req_ready for the winner in that same cycle;
- latch the winner's idx and taps into fir_idx and fir_taps;
- record the winner as owner;
- go to ISSUE.
REQ-018 In ISSUE the scheduler SHALL hold fir_start=1 and the operands stable, and leave ISSUE only in the first cycle with fir_start && !fir_busy (start accepted).
REQ-019 On start acceptance the scheduler SHALL go to WAIT.
- Exception: if fir_done is also high in that same cycle, it SHALL capture fir_returndata and go directly to RESP.
REQ-020 In WAIT, on fir_done=1, the scheduler SHALL capture fir_returndata into the response register and go to RESP.
REQ-021 fir_stall SHALL be 0 in WAIT and in the ISSUE acceptance cycle, and 1 in every other cycle, so that fir never completes into an absent consumer.
REQ-022 In RESP the scheduler SHALL:
- drive rsp_valid[owner]=1 and hold rsp_data stable;
- keep all other rsp_valid bits at 0;
- on rsp_ready[owner], go to IDLE and set the last-served pointer to owner.
REQ-023 At most one transaction SHALL be in flight, and the same requester SHALL NOT be granted twice in a row while any other requester is valid.
REQ-024 req_valid changes outside IDLE SHALL have no effect.
REQ-025 rsp_ready bits of non-owners SHALL be ignored.

Reset
REQ-026 While reset is high, the block SHALL be in IDLE with:
- all outputs 0, including fir_start, req_ready, rsp_valid, rsp_data, fir_idx, fir_taps, sched_busy and timeout_err;
- the watchdog counter cleared;
- last-served pointer = NUM_REQ-1, so that requester 0 has first priority.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately; no response is produced after reset deasserts.

Configuration
REQ-028 Macro FIR_SCHED_TIMEOUT_EN defined:
- a counter SHALL run in WAIT;
- on reaching TIMEOUT_CYCLES without fir_done, the block SHALL pulse timeout_err for one cycle, load rsp_data=0 and go to RESP.
REQ-029 Macro FIR_SCHED_TIMEOUT_EN undefined: no counter SHALL exist, WAIT SHALL be exited only by fir_done, and timeout_err SHALL be tied to 0 (the port remains present).

Structure
REQ-030 Package fir_sched_pkg SHALL hold:
- the state enum;
- DATA_W=32;
- the NUM_REQ default;
- the TIMEOUT_CYCLES default.
REQ-031 Round-robin selection SHALL be one sub-module, fir_rr_arbiter: combinational, with inputs req and last pointer and outputs one-hot grant and index.

Verification
REQ-032 Single request: req_valid=0001, idx=5, taps=0x10, fir_busy=0, fir_done three cycles after start accepted with returndata=0xABCD -> req_ready[0] pulses one cycle; fir_start high exactly one cycle; rsp_valid[0]=1 with rsp_data=0xABCD until rsp_ready[0].
REQ-033 Fairness: req_valid=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Backpressure: fir_busy=1 for 4 cycles during ISSUE -> fir_start held 5 cycles with operands constant; rsp_ready[owner]=0 for 6 cycles -> rsp_valid and rsp_data stable.
REQ-035 Coincident done: fir_done=1 in the start-accept cycle -> result captured and RESP entered on the next edge.
REQ-036 Reset in WAIT: reset pulsed 2 cycles -> all outputs 0; late fir_done ignored; next grant goes to requester 0.
REQ-037 With FIR_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, no fir_done -> timeout_err pulses once after 16 WAIT cycles; rsp_data=0 delivered.

Source files
------------

// File: rtl/fir_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : fir_sched_pkg
// Brief    : Shared types and constants for the fir call scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fir_sched_pkg;

    localparam int DATA_W             = 32;
    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    // Wide enough for any requester index up to the 8-requester maximum.
    localparam int PTR_W              = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fir_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : fir_rr_arbiter
// Brief    : Combinational round-robin picker; the search starts one past 'last'.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);

    logic w_found;

    // Walk the rotated priority order; the inner loop keeps every vector index constant.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req[j] && (((int'(last) + k) % NUM_REQ) == j)) begin
                    w_found  = 1'b1;
                    grant[j] = 1'b1;
                    idx      = PTR_W'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_sched.sv
//------------------------------------------------------------------------------
// Module   : fir_sched
// Brief    : Shares one fir instance among NUM_REQ requesters, one call at a time.
//            Define FIR_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_sched
    import fir_sched_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_idx,
    input  logic [NUM_REQ*DATA_W-1:0] req_taps,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      fir_start,
    input  logic                      fir_busy,
    input  logic                      fir_done,
    output logic                      fir_stall,
    output logic [DATA_W-1:0]         fir_idx,
    output logic [DATA_W-1:0]         fir_taps,
    input  logic [DATA_W-1:0]         fir_returndata,
    output logic                      sched_busy,
    output logic                      timeout_err
);

    state_t              r_state;
    logic [PTR_W-1:0]    r_last;
    logic [PTR_W-1:0]    r_owner;
    logic [NUM_REQ-1:0]  r_owner_oh;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [DATA_W-1:0]   r_fir_idx;
    logic [DATA_W-1:0]   r_fir_taps;
    logic                r_fir_start;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [DATA_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]   w_sel_taps;
    logic                w_owner_ack;

    fir_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant),
        .idx   (w_gnt_idx)
    );

    always_comb begin
        w_sel_idx  = '0;
        w_sel_taps = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_sel_idx  = req_idx[j*DATA_W +: DATA_W];
                w_sel_taps = req_taps[j*DATA_W +: DATA_W];
            end
        end
    end

    // r_rsp_valid is one-hot on the owner in RESP, so non-owner ready bits drop out.
    assign w_owner_ack = |(rsp_ready & r_rsp_valid);

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= PTR_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_owner_oh  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_fir_idx   <= '0;
            r_fir_taps  <= '0;
            r_fir_start <= 1'b0;
`ifdef FIR_SCHED_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
`ifdef FIR_SCHED_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_fir_idx   <= w_sel_idx;
                        r_fir_taps  <= w_sel_taps;
                        r_owner     <= w_gnt_idx;
                        r_owner_oh  <= w_grant;
                        r_fir_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!fir_busy) begin
                        r_fir_start <= 1'b0;
                        if (fir_done) begin
                            r_rsp_data  <= fir_returndata;
                            r_rsp_valid <= r_owner_oh;
                            r_state     <= ST_RESP;
                        end else begin
`ifdef FIR_SCHED_TIMEOUT_EN
                            r_wd_cnt <= '0;
`endif
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (fir_done) begin
                        r_rsp_data  <= fir_returndata;
                        r_rsp_valid <= r_owner_oh;
                        r_state     <= ST_RESP;
                    end
`ifdef FIR_SCHED_TIMEOUT_EN
                    else if (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_rsp_data    <= '0;
                        r_rsp_valid   <= r_owner_oh;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (w_owner_ack) begin
                        r_rsp_valid <= '0;
                        r_last      <= r_owner;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The acceptance pulse and stall depend on live inputs, so reset masks them explicitly.
    assign req_ready  = (!reset && r_state == ST_IDLE) ? w_grant : '0;
    assign fir_stall  = !reset && !((r_state == ST_WAIT) ||
                                    (r_state == ST_ISSUE && !fir_busy));
    assign fir_start  = r_fir_start;
    assign fir_idx    = r_fir_idx;
    assign fir_taps   = r_fir_taps;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign sched_busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fir_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_fir_sched
// Brief    : Self-checking bench for fir_sched with a round-robin reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_sched;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_idx;
    logic [N*DW-1:0] req_taps;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            fir_start;
    logic            fir_busy;
    logic            fir_done;
    logic            fir_stall;
    logic [DW-1:0]   fir_idx;
    logic [DW-1:0]   fir_taps;
    logic [DW-1:0]   fir_returndata;
    logic            sched_busy;
    logic            timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = N - 1;

    fir_sched #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_idx        (req_idx),
        .req_taps       (req_taps),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .fir_start      (fir_start),
        .fir_busy       (fir_busy),
        .fir_done       (fir_done),
        .fir_stall      (fir_stall),
        .fir_idx        (fir_idx),
        .fir_taps       (fir_taps),
        .fir_returndata (fir_returndata),
        .sched_busy     (sched_busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid requester after the last one served.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int j = 0; j < N; j++) begin
            req_idx[j*DW +: DW]  = $urandom;
            req_taps[j*DW +: DW] = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  fir_start,   0);
        check({tag, "_rdy"},    req_ready,   0);
        check({tag, "_rspv"},   rsp_valid,   0);
        check({tag, "_rspd"},   rsp_data,    0);
        check({tag, "_idx"},    fir_idx,     0);
        check({tag, "_taps"},   fir_taps,    0);
        check({tag, "_busy"},   sched_busy,  0);
        check({tag, "_tmo"},    timeout_err, 0);
        check({tag, "_stall"},  fir_stall,   0);
    endtask

    // One complete call: grant, ISSUE with 'busy' stalled cycles, done after 'dly'
    // WAIT cycles (0 = coincident with acceptance), then 'rwait' unacked RESP cycles.
    task automatic txn(input logic [N-1:0] mask, input int busy, input int dly,
                       input int rwait, input int win, input logic [DW-1:0] rdata);
        logic [DW-1:0] e_idx;
        logic [DW-1:0] e_taps;
        logic [N-1:0]  oh;
        oh     = N'(1) << win;
        e_idx  = req_idx[win*DW +: DW];
        e_taps = req_taps[win*DW +: DW];
        req_valid = mask;
        #1;
        check("grant", req_ready, oh);
        check("stall_idle", fir_stall, 1);
        step();
        req_valid = N'($urandom);
        randomize_ops();
        for (int c = 0; c <= busy; c++) begin
            fir_busy       = (c < busy);
            fir_done       = (c == busy && dly == 0);
            fir_returndata = (c == busy && dly == 0) ? rdata : DW'($urandom);
            #1;
            check("issue_start", fir_start, 1);
            check("issue_idx",   fir_idx,   e_idx);
            check("issue_taps",  fir_taps,  e_taps);
            check("issue_stall", fir_stall, (c < busy));
            check("issue_rdy",   req_ready, 0);
            step();
        end
        fir_busy = 1'b0;
        for (int c = 1; c <= dly; c++) begin
            fir_done       = (c == dly);
            fir_returndata = (c == dly) ? rdata : DW'($urandom);
            #1;
            check("wait_start", fir_start, 0);
            check("wait_stall", fir_stall, 0);
            check("wait_rspv",  rsp_valid, 0);
            step();
        end
        fir_done = 1'b0;
        for (int c = 0; c <= rwait; c++) begin
            rsp_ready = (c == rwait) ? (oh | N'($urandom)) : (N'($urandom) & ~oh);
            req_valid = N'($urandom);
            #1;
            check("resp_valid", rsp_valid, oh);
            check("resp_data",  rsp_data,  rdata);
            check("resp_start", fir_start, 0);
            check("resp_stall", fir_stall, 1);
            step();
        end
        rsp_ready = '0;
        req_valid = '0;
        #1;
        check("idle_rspv", rsp_valid, 0);
        check("idle_busy", sched_busy, 0);
        m_last = win;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_last = N - 1;
    endtask

    typedef struct {
        logic [N-1:0]  mask;
        int            busy;
        int            dly;
        int            rwait;
        int            win;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0001, 0, 3, 2, 0, 32'h0000_ABCD};
        vecs[1] = '{4'b1111, 4, 1, 6, 1, 32'h1111_2222};
        vecs[2] = '{4'b1111, 0, 0, 0, 2, 32'h3333_4444};
        vecs[3] = '{4'b0101, 1, 2, 1, 0, 32'h5555_6666};
        vecs[4] = '{4'b0101, 2, 1, 0, 2, 32'h7777_8888};
        vecs[5] = '{4'b1001, 0, 2, 3, 3, 32'h9999_AAAA};
        vecs[6] = '{4'b1001, 3, 0, 1, 0, 32'hBBBB_CCCC};
        vecs[7] = '{4'b0010, 0, 1, 0, 1, 32'hDDDD_EEEE};
        vecs[8] = '{4'b0010, 1, 4, 2, 1, 32'h0102_0304};
        vecs[9] = '{4'b1000, 0, 0, 0, 3, 32'hFFFF_0001};

        rst = 1'b1;
        req_valid = 4'hF;
        req_idx = '0;
        req_taps = '0;
        rsp_ready = 4'hF;
        fir_busy = 1'b0;
        fir_done = 1'b0;
        fir_returndata = '0;
        step();
        step();
        check_all_zero("reset");
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            randomize_ops();
            if (i == 0) begin
                req_idx[DW-1:0]  = 32'd5;
                req_taps[DW-1:0] = 32'h10;
            end
            txn(vecs[i].mask, vecs[i].busy, vecs[i].dly, vecs[i].rwait,
                vecs[i].win, vecs[i].rdata);
        end

        // Fairness with all four requesters continuously valid.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            randomize_ops();
            txn(4'b1111, i % 2, (i % 3) + 1, i % 2, i % 4, DW'(32'hF00 + i));
        end

        // Reset in WAIT abandons the call; a late done must not resurrect it.
        randomize_ops();
        req_valid = 4'b0100;
        #1;
        check("rw_grant", req_ready, 4'b0100);
        step();
        step();
        check("rw_inwait", sched_busy, 1);
        step();
        rst = 1'b1;
        #1;
        check_all_zero("rw_rst1");
        step();
        check_all_zero("rw_rst2");
        rst = 1'b0;
        req_valid = '0;
        fir_done = 1'b1;
        fir_returndata = 32'hDEAD_BEEF;
        step();
        fir_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rw_norsp", rsp_valid, 0);
            check("rw_idle",  sched_busy, 0);
            step();
        end
        m_last = N - 1;
        randomize_ops();
        txn(4'b1111, 0, 1, 0, 0, 32'h1234_5678);

        // Watchdog: no fir_done for the full WAIT window.
        randomize_ops();
        req_valid = 4'b0001;
        #1;
        check("wd_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        for (int c = 1; c <= 16; c++) begin
            #1;
            check("wd_wait_rspv", rsp_valid, 0);
            check("wd_wait_tmo",  timeout_err, 0);
            step();
        end
`ifdef FIR_SCHED_TIMEOUT_EN
        #1;
        check("wd_tmo_pulse", timeout_err, 1);
        check("wd_rspv",      rsp_valid, 4'b0001);
        check("wd_rspd",      rsp_data, 0);
        step();
        check("wd_tmo_once",  timeout_err, 0);
        check("wd_rspv_hold", rsp_valid, 4'b0001);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            check("nowd_rspv", rsp_valid, 0);
            check("nowd_tmo",  timeout_err, 0);
            step();
        end
        fir_done = 1'b1;
        fir_returndata = 32'h0BAD_F00D;
        step();
        fir_done = 1'b0;
        check("nowd_rspv_done", rsp_valid, 4'b0001);
        check("nowd_rspd_done", rsp_data, 32'h0BAD_F00D);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
`endif
        m_last = 0;

        // Randomized calls against the reference round-robin model.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] mask;
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                check("rnd_idle_rdy",  req_ready, 0);
                check("rnd_idle_busy", sched_busy, 0);
                step();
            end
            mask = N'($urandom_range(1, 15));
            randomize_ops();
            txn(mask, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                rr_pick(mask, m_last), DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
